// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory port between the instruction fetch unit and the
// load/store unit. It also formats LSU loads and stores and flags misaligned
// or illegal LSU accesses, which are answered locally without a memory cycle.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [31:0]       ifu_rdata,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [2:0]        lsu_funct3,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [63:0]       lsu_wdata,
    output logic              lsu_resp_valid,
    output logic [63:0]       lsu_rdata,
    output logic              lsu_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [63:0]       mem_rdata
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              owner_lsu_q, owner_lsu_d;
    logic [31:0]       ifu_rdata_q, ifu_rdata_d;
    logic [63:0]       lsu_rdata_q, lsu_rdata_d;

    logic              in_idle, starved, conflict;
    logic              ifu_grant, lsu_grant, lsu_legal;
    logic [2:0]        off;
    logic [63:0]       rd_shift, load_data;
    logic [7:0]        store_mask;

    // An LSU access is legal when funct3 names a real load/store and the
    // address is naturally aligned for the access size.
    function automatic logic lsu_is_legal(input logic wen, input logic [2:0] f3,
                                          input logic [2:0] a);
        logic ok;
        ok = wen ? !f3[2] : (f3 != 3'b111);
        case (f3[1:0])
            2'b01:   ok = ok && (a[0] == 1'b0);
            2'b10:   ok = ok && (a[1:0] == 2'b00);
            2'b11:   ok = ok && (a == 3'b000);
            default: ok = ok;
        endcase
        return ok;
    endfunction

    // Request-side handshake: ready only in IDLE, and only the winner sees it.
    always_comb begin
        in_idle       = (state_q == S_IDLE) && !rst;
        starved       = (starve_q == 4'(STARVE_LIMIT));
        conflict      = ifu_req_valid && lsu_req_valid;
        ifu_req_ready = in_idle && !(conflict && !starved);
        lsu_req_ready = in_idle && !(conflict && starved);
        ifu_grant     = ifu_req_valid && ifu_req_ready;
        lsu_grant     = lsu_req_valid && lsu_req_ready;
        lsu_legal     = lsu_is_legal(lsu_wen, lsu_funct3, lsu_addr[2:0]);
    end

    // Lane extraction and extension of load data, and the store byte mask.
    always_comb begin
        off      = addr_q[2:0];
        rd_shift = mem_rdata >> {off, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{56{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  load_data = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_data = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'b100:  load_data = {56'd0, rd_shift[7:0]};
            3'b101:  load_data = {48'd0, rd_shift[15:0]};
            3'b110:  load_data = {32'd0, rd_shift[31:0]};
            default: load_data = rd_shift;
        endcase
        case (funct3_q[1:0])
            2'b00:   store_mask = 8'h01 << off;
            2'b01:   store_mask = 8'h03 << off;
            2'b10:   store_mask = 8'h0F << off;
            default: store_mask = 8'hFF;
        endcase
    end

    // Memory-side request fields and response strobes, all decoded from state.
    always_comb begin
        mem_req_valid  = (state_q == S_ISSUE);
        mem_addr       = mem_req_valid ? {addr_q[ADDR_W-1:3], 3'b000} : '0;
        mem_wen        = mem_req_valid && wen_q;
        mem_wmask      = mem_wen ? store_mask : 8'h00;
        mem_wdata      = mem_wen ? (wdata_q << {off, 3'b000}) : 64'd0;
        ifu_resp_valid = (state_q == S_RESP) && !owner_lsu_q;
        lsu_resp_valid = ((state_q == S_RESP) && owner_lsu_q) || (state_q == S_ERR);
        lsu_err        = (state_q == S_ERR);
        ifu_rdata      = ifu_rdata_q;
        lsu_rdata      = lsu_rdata_q;
    end

    // Next-state logic: arbitration, request capture and response formatting.
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        addr_d      = addr_q;
        wen_d       = wen_q;
        funct3_d    = funct3_q;
        wdata_d     = wdata_q;
        owner_lsu_d = owner_lsu_q;
        ifu_rdata_d = ifu_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (lsu_grant) begin
                    addr_d      = lsu_addr;
                    wen_d       = lsu_wen;
                    funct3_d    = lsu_funct3;
                    wdata_d     = lsu_wdata;
                    owner_lsu_d = 1'b1;
                    if (ifu_req_valid && (starve_q != 4'hF)) begin
                        starve_d = starve_q + 4'd1;
                    end
                    if (lsu_legal) begin
                        state_d = S_ISSUE;
                    end else begin
                        lsu_rdata_d = 64'd0;
                        state_d     = S_ERR;
                    end
                end else if (ifu_grant) begin
                    addr_d      = ifu_addr;
                    wen_d       = 1'b0;
                    funct3_d    = 3'b010;
                    wdata_d     = 64'd0;
                    owner_lsu_d = 1'b0;
                    starve_d    = 4'd0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    if (owner_lsu_q) begin
                        lsu_rdata_d = wen_q ? 64'd0 : load_data;
                    end else begin
                        ifu_rdata_d = addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0];
                    end
                    state_d = S_RESP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-request registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            starve_q    <= 4'd0;
            addr_q      <= '0;
            wen_q       <= 1'b0;
            funct3_q    <= 3'b000;
            wdata_q     <= 64'd0;
            owner_lsu_q <= 1'b0;
            ifu_rdata_q <= 32'd0;
            lsu_rdata_q <= 64'd0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            wen_q       <= wen_d;
            funct3_q    <= funct3_d;
            wdata_q     <= wdata_d;
            owner_lsu_q <= owner_lsu_d;
            ifu_rdata_q <= ifu_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: a behavioural memory with random handshake
// delays, directed scenarios and randomized LSU/IFU traffic.
module tb_mem_port_arbiter;

    localparam int STARVE = 4;

    logic        clk, rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [63:0] ifu_addr;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_err;
    logic [2:0]  lsu_funct3;
    logic [63:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic [63:0] addr;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  mask;
    } mreq_t;

    mreq_t       req_q[$];
    logic [63:0] mem [16];
    int          cyc = 0;
    int          passed = 0;
    int          total = 0;
    int          rsp_wait = -1;
    int          rdy_wait = 0;
    bit          in_req = 0;
    int          force_rdy_wait = -1;
    int          force_rsp_wait = -1;
    int          last_rsp_cyc = -1;
    logic [63:0] rsp_data;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("[TB] FAIL global_timeout");
        $fatal(1, "[TB] simulation did not finish");
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    // Behavioural memory: random ready delay, random response delay, and an
    // occasional junk response pulse on the handshake cycle that must be ignored.
    initial begin
        mem_req_ready  = 0;
        mem_resp_valid = 0;
        mem_rdata      = 0;
        forever begin
            @(negedge clk);
            mem_req_ready  = 0;
            mem_resp_valid = 0;
            mem_rdata      = {$urandom, $urandom};
            if (rsp_wait == 0) begin
                mem_resp_valid = 1;
                mem_rdata      = rsp_data;
                rsp_wait       = -1;
                last_rsp_cyc   = cyc;
            end else if (rsp_wait > 0) begin
                rsp_wait--;
            end else if (mem_req_valid) begin
                if (!in_req) begin
                    in_req   = 1;
                    rdy_wait = (force_rdy_wait >= 0) ? force_rdy_wait : int'($urandom_range(0, 2));
                end
                if (rdy_wait > 0) begin
                    rdy_wait--;
                end else begin
                    mreq_t r;
                    mem_req_ready = 1;
                    in_req        = 0;
                    r.addr  = mem_addr;
                    r.wen   = mem_wen;
                    r.wdata = mem_wdata;
                    r.mask  = mem_wmask;
                    req_q.push_back(r);
                    if (mem_wen) begin
                        for (int b = 0; b < 8; b++) begin
                            if (mem_wmask[b]) mem[mem_addr[6:3]][b*8 +: 8] = mem_wdata[b*8 +: 8];
                        end
                        rsp_data = {$urandom, $urandom};
                    end else begin
                        rsp_data = mem[mem_addr[6:3]];
                    end
                    rsp_wait = (force_rsp_wait >= 0) ? force_rsp_wait : int'($urandom_range(0, 2));
                    if ($urandom_range(0, 3) == 0) mem_resp_valid = 1;
                end
            end
        end
    end

    // One complete IFU or LSU transaction with all expectations derived from
    // the access rules and the bench memory contents.
    task automatic applyStimulus(input bit is_ifu, input bit wen, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input int exp_lat);
        int          offi, size, bits, n_before, acc, rcyc, w;
        bit          legal, got;
        logic [63:0] field, m, exp_rd, exp_wd, exp_addr;
        logic [7:0]  exp_mask;
        int          mask_int;
        mreq_t       r;
        offi     = int'(addr[2:0]);
        size     = 1 << f3[1:0];
        bits     = size * 8;
        legal    = is_ifu || ((wen ? !f3[2] : (f3 != 3'b111)) && ((offi % size) == 0));
        exp_addr = {addr[63:3], 3'b000};
        if (is_ifu) begin
            exp_rd = addr[2] ? (mem[addr[6:3]] >> 32) : (mem[addr[6:3]] & 64'hFFFF_FFFF);
        end else if (wen || !legal) begin
            exp_rd = 64'd0;
        end else begin
            field = mem[addr[6:3]] >> (offi * 8);
            if (bits < 64) begin
                m     = (64'd1 << bits) - 64'd1;
                field = field & m;
                if (!f3[2] && field[bits-1]) field = field | ~m;
            end
            exp_rd = field;
        end
        mask_int = ((1 << size) - 1) << offi;
        exp_mask = (is_ifu || !wen) ? 8'h00 : mask_int[7:0];
        exp_wd   = (is_ifu || !wen) ? 64'd0 : (wdata << (offi * 8));
        n_before = req_q.size();

        @(negedge clk);
        if (is_ifu) begin
            ifu_req_valid = 1;
            ifu_addr      = addr;
        end else begin
            lsu_req_valid = 1;
            lsu_wen       = wen;
            lsu_funct3    = f3;
            lsu_addr      = addr;
            lsu_wdata     = wdata;
        end
        #1;
        w = 0;
        while (!(is_ifu ? ifu_req_ready : lsu_req_ready) && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (w >= 20) begin
            checkOutput("accept_timeout", 0, 1);
            ifu_req_valid = 0;
            lsu_req_valid = 0;
            return;
        end
        acc = cyc;
        @(negedge clk);
        ifu_req_valid = 0;
        lsu_req_valid = 0;
        lsu_addr      = {$urandom, $urandom};
        lsu_wdata     = {$urandom, $urandom};
        got = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (is_ifu ? ifu_resp_valid : lsu_resp_valid) begin
                got = 1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checkOutput("resp_timeout", 0, 1);
            return;
        end
        rcyc = cyc;
        if (is_ifu) begin
            checkOutput("ifu_rdata", {32'd0, ifu_rdata}, exp_rd);
        end else begin
            checkOutput("lsu_rdata", lsu_rdata, exp_rd);
            checkOutput("lsu_err", lsu_err, !legal);
        end
        if (legal) begin
            checkOutput("mem_req_count", req_q.size(), n_before + 1);
            if (req_q.size() > 0) begin
                r = req_q.pop_back();
                checkOutput("mem_addr", r.addr, exp_addr);
                checkOutput("mem_wen", r.wen, !is_ifu && wen);
                checkOutput("mem_wmask", r.mask, exp_mask);
                checkOutput("mem_wdata", r.wdata, exp_wd);
            end
            checkOutput("resp_after_mem", rcyc, last_rsp_cyc + 1);
        end else begin
            checkOutput("err_no_mem_req", req_q.size(), n_before);
            checkOutput("err_latency", rcyc - acc, 1);
        end
        if (exp_lat >= 0) checkOutput("latency", rcyc - acc, exp_lat);
        @(negedge clk);
        #1;
        checkOutput("resp_one_cycle", {ifu_resp_valid, lsu_resp_valid}, 2'b00);
        req_q.delete();
    endtask

    initial begin
        int          grants[$];
        int          conflict_err, w, n_before;
        bit          stray;
        logic [63:0] a;
        logic [2:0]  f3;
        bit          is_ifu, wen;

        rst = 1;
        ifu_req_valid = 1;
        lsu_req_valid = 1;
        ifu_addr = 64'h8000_0000;
        lsu_addr = 64'h8000_0000;
        lsu_wen = 0;
        lsu_funct3 = 3'b011;
        lsu_wdata = 0;
        for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom};
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_ifu_ready", ifu_req_ready, 0);
        checkOutput("rst_lsu_ready", lsu_req_ready, 0);
        checkOutput("rst_mem_req_valid", mem_req_valid, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_resp_valid", {ifu_resp_valid, lsu_resp_valid, lsu_err}, 0);
        checkOutput("rst_rdata", lsu_rdata | {32'd0, ifu_rdata}, 0);
        ifu_req_valid = 0;
        lsu_req_valid = 0;
        @(negedge clk);
        rst = 0;

        // Doubleword load with ready and response each one cycle late.
        force_rdy_wait = 1;
        force_rsp_wait = 0;
        mem[4'hE] = 64'h1122334455667788;
        applyStimulus(0, 0, 3'b011, 64'h8000_8FF0, 0, 4);
        checkOutput("ld_directed", lsu_rdata, 64'h1122334455667788);
        force_rdy_wait = -1;
        force_rsp_wait = -1;

        // Byte loads, signed and unsigned, from the same lane.
        mem[0] = 64'h0000_0000_80FF_0000;
        applyStimulus(0, 0, 3'b000, 64'h8000_0003, 0, -1);
        checkOutput("lb_directed", lsu_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        mem[0] = 64'h0000_0000_80FF_0000;
        applyStimulus(0, 0, 3'b100, 64'h8000_0003, 0, -1);
        checkOutput("lbu_directed", lsu_rdata, 64'h0000_0000_0000_0080);

        // Halfword store into the top lane, then illegal accesses.
        applyStimulus(0, 1, 3'b001, 64'h8000_0006, 64'hABCD, -1);
        checkOutput("sh_lane", mem[0][63:48], 16'hABCD);
        applyStimulus(0, 1, 3'b010, 64'h8000_0002, 64'h1234, -1);
        applyStimulus(0, 0, 3'b111, 64'h8000_0008, 0, -1);
        applyStimulus(0, 1, 3'b100, 64'h8000_0008, 64'h55, -1);

        // Instruction fetch from the upper word.
        mem[0] = 64'hDEAD_BEEF_0BAD_F00D;
        applyStimulus(1, 0, 3'b010, 64'h8000_0004, 0, -1);
        checkOutput("ifu_upper_word", {32'd0, ifu_rdata}, 64'hDEAD_BEEF);

        // Both requesters continuously valid from a fresh reset.
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        conflict_err = 0;
        for (int c = 0; c < 400 && grants.size() < 15; c++) begin
            @(negedge clk);
            ifu_req_valid = 1;
            lsu_req_valid = 1;
            lsu_wen    = 0;
            lsu_funct3 = 3'b011;
            lsu_addr   = 64'h8000_0000 + 64'(8 * $urandom_range(0, 15));
            ifu_addr   = 64'h8000_0000 + 64'(4 * $urandom_range(0, 31));
            #1;
            if (ifu_req_ready && lsu_req_ready) conflict_err++;
            if (ifu_req_ready) grants.push_back(1);
            else if (lsu_req_ready) grants.push_back(0);
        end
        ifu_req_valid = 0;
        lsu_req_valid = 0;
        checkOutput("arb_grant_count", grants.size(), 15);
        checkOutput("arb_conflict_ready", conflict_err, 0);
        for (int i = 0; i < grants.size(); i++) begin
            checkOutput($sformatf("arb_grant_%0d", i), grants[i], ((i % (STARVE + 1)) == STARVE));
        end
        repeat (15) @(negedge clk);
        req_q.delete();

        // Reset while waiting for the memory response.
        force_rsp_wait = 4;
        n_before = req_q.size();
        @(negedge clk);
        lsu_req_valid = 1;
        lsu_wen = 0;
        lsu_funct3 = 3'b011;
        lsu_addr = 64'h8000_0010;
        #1;
        w = 0;
        while (!lsu_req_ready && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        @(negedge clk);
        lsu_req_valid = 0;
        #1;
        w = 0;
        while (req_q.size() == n_before && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        checkOutput("rst_wait_reached", w < 20, 1);
        @(posedge clk);
        #1;
        rst = 1;
        lsu_req_valid = 1;
        #1;
        checkOutput("rstw_mem_req_valid", mem_req_valid, 0);
        checkOutput("rstw_readies", {ifu_req_ready, lsu_req_ready}, 0);
        checkOutput("rstw_resp", {ifu_resp_valid, lsu_resp_valid, lsu_err}, 0);
        checkOutput("rstw_rdata", lsu_rdata, 0);
        lsu_req_valid = 0;
        @(negedge clk);
        rst = 0;
        force_rsp_wait = -1;
        stray = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (ifu_resp_valid || lsu_resp_valid || mem_req_valid) stray = 1;
        end
        checkOutput("late_resp_ignored", stray, 0);
        req_q.delete();
        applyStimulus(0, 0, 3'b011, 64'h8000_0018, 0, -1);

        // Randomized traffic, biased toward aligned (legal) addresses.
        for (int t = 0; t < 60; t++) begin
            is_ifu = ($urandom_range(0, 3) == 0);
            wen    = $urandom_range(0, 1);
            f3     = 3'($urandom_range(0, 7));
            a      = 64'h8000_0000 + 64'($urandom_range(0, 127));
            if (is_ifu) a[1:0] = 2'b00;
            else if ($urandom_range(0, 1) == 1) a = a & ~((64'd1 << f3[1:0]) - 64'd1);
            applyStimulus(is_ifu, wen, f3, a, {$urandom, $urandom}, -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences and shares the single 64-bit physical-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Owns the memory-access rules for the LSU side:
  - load sign/zero extension by funct3;
  - store byte-mask and data-lane generation;
  - misalignment detection.
- Sits between IFU/LSU and the pmem interface.
- Replaces the combinational, event-driven data-memory access with a clocked request/response handshake.

Parameters:
- STARVE_LIMIT, 4: consecutive lost arbitrations after which IFU is granted over LSU (1..15).
- ADDR_W, 64: address width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ifu_req_valid  in  1  fetch request
- ifu_req_ready  out  1  fetch request accepted when valid&ready
- ifu_addr  in  ADDR_W  fetch address; bits [1:0] ignored
- ifu_resp_valid  out  1  one-cycle fetch response strobe
- ifu_rdata  out  32  instruction word
- lsu_req_valid  in  1  load/store request
- lsu_req_ready  out  1  LSU request accepted when valid&ready
- lsu_wen  in  1  1=store, 0=load
- lsu_funct3  in  3  RISC-V funct3 of the access
- lsu_addr  in  ADDR_W  byte address
- lsu_wdata  in  64  store data, LSB-aligned
- lsu_resp_valid  out  1  one-cycle LSU response strobe
- lsu_rdata  out  64  extended load data (0 for stores and errors)
- lsu_err  out  1  qualifies lsu_resp_valid: misaligned or illegal funct3
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts when valid&ready
- mem_addr  out  ADDR_W  request address with [2:0] forced to 0
- mem_wen  out  1  write request
- mem_wdata  out  64  lane-shifted write data
- mem_wmask  out  8  byte-enable mask
- mem_resp_valid  in  1  read data / write ack strobe
- mem_rdata  in  64  aligned doubleword

Behaviour:
- Reset (async, rst=1):
  - FSM to IDLE; starve counter 0.
  - All outputs 0 except ifu_req_ready=lsu_req_ready=0.
  - Any mem_resp_valid arriving after reset is ignored.
- FSM states: IDLE, ISSUE, WAIT, RESP, ERR.
- IDLE:
  - ifu_req_ready and lsu_req_ready are both 1 only in IDLE. Each is gated so that only the winner sees ready=1 in a conflict cycle.
  - Both valid: LSU wins unless starve counter == STARVE_LIMIT, in which case IFU wins.
  - Starve counter: +1 when IFU loses a conflict (saturating); cleared on any IFU grant.
  - Winner's request is registered (addr, wen, funct3, wdata, owner).
  - Legal access -> ISSUE. Illegal LSU access -> ERR (no memory transaction).
- ISSUE:
  - mem_req_valid=1 with stable fields until mem_req_ready; then -> WAIT.
  - mem_resp_valid in the same cycle as the handshake is not accepted; the response is sampled only in WAIT.
- WAIT: on mem_resp_valid, capture formatted data -> RESP.
- RESP:
  - Owner's resp_valid=1 for exactly one cycle, then -> IDLE.
  - No new request is accepted in this cycle.
- ERR: lsu_resp_valid=1, lsu_err=1, lsu_rdata=0 for one cycle -> IDLE.
- Minimum latency: accept at cycle N, mem_req_valid at N+1, response sampled at N+2 at the earliest, resp_valid at N+3.
- Offset: off=addr[2:0].
- Loads (read byte field of mem_rdata starting at off*8):
  - 000 sign-extend 8 bits; 001 sign-extend 16; 010 sign-extend 32; 011 full 64.
  - 100 zero-extend 8; 101 zero-extend 16; 110 zero-extend 32.
  - 111 illegal.
- Stores:
  - 000 mask 0x01<<off; 001 0x03<<off; 010 0x0F<<off; 011 0xFF.
  - mem_wdata = lsu_wdata << (off*8).
  - funct3[2]=1 illegal.
- Misaligned (illegal) when:
  - halfword: addr[0]!=0;
  - word: addr[1:0]!=0;
  - doubleword: addr[2:0]!=0.
- Loads drive mem_wmask=0 and mem_wdata=0.
- IFU: mem_wen=0, mask 0; ifu_rdata = addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
- Response data outputs hold their value until the next response; resp_valid marks validity.

Test Plan:
- LSU ld at 0x80008FF0, memory returns 0x1122334455667788 with ready and response each one cycle late -> lsu_resp_valid at accept+4, lsu_rdata=0x1122334455667788, lsu_err=0.
- LSU lb at 0x80000003, mem_rdata=0x00000000_80FF0000 -> byte 0x80, lsu_rdata=0xFFFFFFFFFFFFFF80. Same access with lbu -> 0x0000000000000080.
- LSU sh at 0x80000006, wdata=0xABCD -> mem_addr=0x80000000, mem_wmask=0xC0, mem_wdata=0xABCD000000000000; on ack, lsu_rdata=0.
- LSU sw at 0x80000002 -> no mem_req_valid; ERR for one cycle with lsu_err=1. Likewise funct3=111 load and funct3=100 store.
- IFU and LSU continuously valid, STARVE_LIMIT=4 -> 4 LSU grants, then 1 IFU grant, pattern repeats. IFU at 0x80000004 returns mem_rdata[63:32].
- rst asserted while in WAIT -> outputs 0 immediately. A later mem_resp_valid produces no resp_valid. A next request completes normally.
